vec_regfile_param: RTL and testbench

- Parametrised scalar plus vector register file for the vector processor datapath.
- Scalar GPRs and vector registers are held in separate arrays, each with independent write ports.
- Reads are registered, with write-first bypass, and vector writes can be masked by vlen.
- An element streamer feeds vector stores (vector SW) into data memory one element per cycle, using a valid/ready handshake.

---
 rtl/vec_regfile_param.sv | 208 ++++++++++++++++++++
 tb/tb_vec_regfile_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_regfile_param.sv
// Scalar + vector register file with registered write-first reads, vlen-masked
// vector writes and a valid/ready element streamer for vector stores.

// One lane: element i of every vector register, with two registered read ports
// and one combinational port for the store streamer.
module vec_regfile_lane #(
  parameter int DW    = 32,
  parameter int NVREG = 4,
  parameter int VAW   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [VAW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic [VAW-1:0] raddr1,
  input  logic [VAW-1:0] raddr2,
  input  logic [VAW-1:0] saddr,
  input  logic           rok1,
  input  logic           rok2,
  input  logic           sok,
  output logic [DW-1:0]  rdata1,
  output logic [DW-1:0]  rdata2,
  output logic [DW-1:0]  sdata
);
  logic [NVREG-1:0][DW-1:0] mem;
  logic [DW-1:0]            rd1_nx, rd2_nx;

  // Read muxes: out-of-range addresses read zero, same-cycle write bypasses.
  always_comb begin
    rd1_nx = '0;
    rd2_nx = '0;
    sdata  = '0;
    if (rok1) rd1_nx = (we && waddr == raddr1) ? wdata : mem[raddr1];
    if (rok2) rd2_nx = (we && waddr == raddr2) ? wdata : mem[raddr2];
    if (sok)  sdata  = (we && waddr == saddr)  ? wdata : mem[saddr];
  end

  // Storage; 'we' already folds in address range and vlen mask.
  always_ff @(posedge clk) begin
    if (!rst_n)  mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  // Registered read data, sampled every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      rdata1 <= rd1_nx;
      rdata2 <= rd2_nx;
    end
  end
endmodule

module vec_regfile_param #(
  parameter  int DW       = 32,
  parameter  int NSREG    = 8,
  parameter  int NVREG    = 4,
  parameter  int VLANES   = 8,
  parameter  int VLEN_IDX = 7,
  localparam int SAW      = $clog2(NSREG),
  localparam int VAW      = $clog2(NVREG),
  localparam int EW       = $clog2(VLANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SAW-1:0]       s_raddr1,
  input  logic [SAW-1:0]       s_raddr2,
  output logic [DW-1:0]        s_rdata1,
  output logic [DW-1:0]        s_rdata2,
  input  logic                 s_we,
  input  logic [SAW-1:0]       s_waddr,
  input  logic [DW-1:0]        s_wdata,
  input  logic [VAW-1:0]       v_raddr1,
  input  logic [VAW-1:0]       v_raddr2,
  output logic [VLANES*DW-1:0] v_rdata1,
  output logic [VLANES*DW-1:0] v_rdata2,
  input  logic                 v_we,
  input  logic [VAW-1:0]       v_waddr,
  input  logic [VLANES*DW-1:0] v_wdata,
  input  logic                 v_mask_en,
  output logic [DW-1:0]        vlen,
  input  logic                 st_start,
  input  logic [VAW-1:0]       st_vreg,
  input  logic [EW:0]          st_cnt,
  output logic [DW-1:0]        st_data,
  output logic                 st_valid,
  input  logic                 st_ready,
  output logic                 st_busy,
  output logic                 st_done
);
  localparam logic [VAW:0] NV_W = (VAW+1)'(NVREG);
  localparam logic [EW:0]  VL_W = (EW+1)'(VLANES);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} st_state_t;

  logic [NSREG-1:0][DW-1:0]  sreg;
  logic [VLANES-1:0]         lane_we;
  logic [VLANES-1:0][DW-1:0] lane_rd1, lane_rd2, lane_sd;
  logic                      v_wok, v_rok1, v_rok2, src_ok;

  st_state_t                 state, state_nx;
  logic [VAW-1:0]            vreg_q, src_vreg;
  logic [EW:0]               cnt_q, cnt_in;
  logic [EW-1:0]             idx_q, src_idx;
  logic                      last;

  assign vlen   = sreg[VLEN_IDX];
  assign v_wok  = {1'b0, v_waddr}  < NV_W;
  assign v_rok1 = {1'b0, v_raddr1} < NV_W;
  assign v_rok2 = {1'b0, v_raddr2} < NV_W;

  // Scalar array write port.
  always_ff @(posedge clk) begin
    if (!rst_n)    sreg <= '0;
    else if (s_we) sreg[s_waddr] <= s_wdata;
  end

  // Scalar registered reads with write-first bypass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_rdata1 <= '0;
      s_rdata2 <= '0;
    end else begin
      s_rdata1 <= (s_we && s_waddr == s_raddr1) ? s_wdata : sreg[s_raddr1];
      s_rdata2 <= (s_we && s_waddr == s_raddr2) ? s_wdata : sreg[s_raddr2];
    end
  end

  // Lane i writes when i < vlen (old vlen, so a same-cycle scalar write to
  // VLEN_IDX cannot move the mask); vlen >= VLANES enables every lane.
  genvar i;
  generate
    for (i = 0; i < VLANES; i++) begin : g_lane
      assign lane_we[i] = v_we && v_wok && (!v_mask_en || (vlen > DW'(i)));
      vec_regfile_lane #(.DW(DW), .NVREG(NVREG), .VAW(VAW)) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (lane_we[i]),
        .waddr  (v_waddr),
        .wdata  (v_wdata[i*DW +: DW]),
        .raddr1 (v_raddr1),
        .raddr2 (v_raddr2),
        .saddr  (src_vreg),
        .rok1   (v_rok1),
        .rok2   (v_rok2),
        .sok    (src_ok),
        .rdata1 (lane_rd1[i]),
        .rdata2 (lane_rd2[i]),
        .sdata  (lane_sd[i])
      );
      assign v_rdata1[i*DW +: DW] = lane_rd1[i];
      assign v_rdata2[i*DW +: DW] = lane_rd2[i];
    end
  endgenerate

  // Element to load into st_data: element 0 of st_vreg on start, else idx+1.
  always_comb begin
    cnt_in   = (st_cnt > VL_W) ? VL_W : st_cnt;
    last     = ({1'b0, idx_q} + (EW+1)'(1)) == cnt_q;
    src_vreg = (state == ST_IDLE) ? st_vreg : vreg_q;
    src_idx  = (state == ST_IDLE) ? '0 : idx_q + EW'(1);
    src_ok   = {1'b0, src_vreg} < NV_W;
  end

  // Streamer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Streamer next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (st_start) state_nx = (cnt_in == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: if (st_ready && last) state_nx = ST_DONE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Streamer outputs.
  always_comb begin
    st_valid = (state == ST_STREAM);
    st_busy  = (state == ST_STREAM);
    st_done  = (state == ST_DONE);
  end

  // Streamer datapath: each element is fetched at the edge it becomes current.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vreg_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      st_data <= '0;
    end else if (state == ST_IDLE && st_start) begin
      vreg_q  <= st_vreg;
      cnt_q   <= cnt_in;
      idx_q   <= '0;
      st_data <= lane_sd[src_idx];
    end else if (state == ST_STREAM && st_ready && !last) begin
      idx_q   <= src_idx;
      st_data <= lane_sd[src_idx];
    end
  end
endmodule

// File: tb/tb_vec_regfile_param.sv
// Directed bench for vec_regfile_param: table of register-file vectors plus
// hand-written streamer sequences. NVREG=3 so address 3 is out of range.
module tb_vec_regfile_param;
  localparam int DW = 32, NSREG = 8, NVREG = 3, VLANES = 8, VLEN_IDX = 7;
  localparam int VW = VLANES * DW;

  logic          clk = 0, rst_n = 0;
  logic [2:0]    s_raddr1 = 0, s_raddr2 = 0, s_waddr = 0;
  logic [31:0]   s_rdata1, s_rdata2, s_wdata = 0, vlen, st_data;
  logic          s_we = 0, v_we = 0, v_mask_en = 0;
  logic [1:0]    v_raddr1 = 0, v_raddr2 = 0, v_waddr = 0, st_vreg = 0;
  logic [VW-1:0] v_rdata1, v_rdata2, v_wdata = 0;
  logic          st_start = 0, st_valid, st_ready = 0, st_busy, st_done;
  logic [3:0]    st_cnt = 0;

  int n_tests = 0, n_fail = 0;

  vec_regfile_param #(.DW(DW), .NSREG(NSREG), .NVREG(NVREG), .VLANES(VLANES),
                      .VLEN_IDX(VLEN_IDX)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_raddr1(s_raddr1), .s_raddr2(s_raddr2), .s_rdata1(s_rdata1), .s_rdata2(s_rdata2),
    .s_we(s_we), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .v_raddr1(v_raddr1), .v_raddr2(v_raddr2), .v_rdata1(v_rdata1), .v_rdata2(v_rdata2),
    .v_we(v_we), .v_waddr(v_waddr), .v_wdata(v_wdata), .v_mask_en(v_mask_en),
    .vlen(vlen), .st_start(st_start), .st_vreg(st_vreg), .st_cnt(st_cnt),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_busy(st_busy), .st_done(st_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          s_we;
    logic [2:0]    s_waddr;
    logic [31:0]   s_wdata;
    logic [2:0]    s_ra1, s_ra2;
    logic          v_we;
    logic [1:0]    v_waddr;
    logic [VW-1:0] v_wdata;
    logic          v_mask;
    logic [1:0]    v_ra1, v_ra2;
    logic [31:0]   e_s1, e_s2;
    logic [VW-1:0] e_v1, e_v2;
    logic [31:0]   e_vlen;
  } vec_t;

  vec_t tbl[14];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Lanes 0..n-1 hold base+i, the rest zero.
  function automatic logic [VW-1:0] ln(input logic [31:0] base, input int n);
    logic [VW-1:0] r = '0;
    for (int i = 0; i < VLANES; i++)
      if (i < n) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  function automatic vec_t vr(input int swe, input int swa, input logic [31:0] swd,
                              input int sr1, input int sr2, input int vwe, input int vwa,
                              input logic [VW-1:0] vwd, input int vm, input int vr1,
                              input int vr2, input logic [31:0] es1, input logic [31:0] es2,
                              input logic [VW-1:0] ev1, input logic [VW-1:0] ev2,
                              input logic [31:0] evl);
    vec_t r;
    r.s_we = swe[0]; r.s_waddr = swa[2:0]; r.s_wdata = swd;
    r.s_ra1 = sr1[2:0]; r.s_ra2 = sr2[2:0];
    r.v_we = vwe[0]; r.v_waddr = vwa[1:0]; r.v_wdata = vwd; r.v_mask = vm[0];
    r.v_ra1 = vr1[1:0]; r.v_ra2 = vr2[1:0];
    r.e_s1 = es1; r.e_s2 = es2; r.e_v1 = ev1; r.e_v2 = ev2; r.e_vlen = evl;
    return r;
  endfunction

  task automatic stream_start(input logic [1:0] vreg, input logic [3:0] cnt);
    st_vreg = vreg; st_cnt = cnt; st_start = 1;
    tick;
    st_start = 0;
  endtask

  initial begin
    int  n;
    bit  got_done;
    //          swe swa swdata        sr1 sr2 vwe vwa vwdata        vm vr1 vr2 e_s1          e_s2          e_v1          e_v2          e_vlen
    tbl[0]  = vr(1, 3, 32'hDEADBEEF, 3, 0, 0, 0, '0,           0, 0, 3, 32'hDEADBEEF, 0,            '0,           '0,           0);
    tbl[1]  = vr(0, 0, 0,            3, 3, 0, 0, '0,           0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, '0,           '0,           0);
    tbl[2]  = vr(1, 7, 3,            7, 0, 0, 0, '0,           0, 0, 0, 3,            0,            '0,           '0,           3);
    tbl[3]  = vr(0, 0, 0,            7, 7, 1, 1, ln(32'h10,8), 1, 1, 1, 3,            3,            ln(32'h10,3), ln(32'h10,3), 3);
    tbl[4]  = vr(0, 0, 0,            7, 3, 0, 0, '0,           0, 1, 0, 3,            32'hDEADBEEF, ln(32'h10,3), '0,           3);
    tbl[5]  = vr(0, 0, 0,            7, 3, 1, 1, ln(32'h10,8), 0, 1, 2, 3,            32'hDEADBEEF, ln(32'h10,8), '0,           3);
    tbl[6]  = vr(0, 0, 0,            3, 7, 1, 3, ln(32'h50,8), 0, 3, 1, 32'hDEADBEEF, 3,            '0,           ln(32'h10,8), 3);
    tbl[7]  = vr(0, 0, 0,            3, 7, 0, 0, '0,           0, 0, 2, 32'hDEADBEEF, 3,            '0,           '0,           3);
    tbl[8]  = vr(1, 7, 5,            7, 3, 1, 2, ln(32'h60,8), 1, 2, 1, 5,            32'hDEADBEEF, ln(32'h60,3), ln(32'h10,8), 5);
    tbl[9]  = vr(0, 0, 0,            7, 3, 0, 0, '0,           0, 2, 0, 5,            32'hDEADBEEF, ln(32'h60,3), '0,           5);
    tbl[10] = vr(1, 7, 0,            0, 7, 1, 0, ln(32'h70,8), 1, 0, 2, 0,            0,            ln(32'h70,5), ln(32'h60,3), 0);
    tbl[11] = vr(1, 0, 32'h12345678, 0, 3, 1, 0, ln(32'h80,8), 1, 0, 1, 32'h12345678, 32'hDEADBEEF, ln(32'h70,5), ln(32'h10,8), 0);
    tbl[12] = vr(1, 7, 100,          7, 0, 0, 0, '0,           0, 0, 2, 100,          32'h12345678, ln(32'h70,5), ln(32'h60,3), 100);
    tbl[13] = vr(0, 0, 0,            0, 7, 1, 0, ln(32'h90,8), 1, 0, 2, 32'h12345678, 100,          ln(32'h90,8), ln(32'h60,3), 100);

    // Reset state
    rst_n = 0;
    tick; tick;
    chk("rst_s_rdata1", s_rdata1, 0);
    chk("rst_v_rdata1", v_rdata1, 0);
    chk("rst_vlen", vlen, 0);
    chk("rst_st_valid", st_valid, 0);
    chk("rst_st_busy", st_busy, 0);
    chk("rst_st_done", st_done, 0);
    rst_n = 1;

    // Register-file vector table
    for (int i = 0; i < 14; i++) begin
      s_we = tbl[i].s_we; s_waddr = tbl[i].s_waddr; s_wdata = tbl[i].s_wdata;
      s_raddr1 = tbl[i].s_ra1; s_raddr2 = tbl[i].s_ra2;
      v_we = tbl[i].v_we; v_waddr = tbl[i].v_waddr; v_wdata = tbl[i].v_wdata;
      v_mask_en = tbl[i].v_mask; v_raddr1 = tbl[i].v_ra1; v_raddr2 = tbl[i].v_ra2;
      tick;
      chk($sformatf("vec%0d_s_rdata1", i), s_rdata1, tbl[i].e_s1);
      chk($sformatf("vec%0d_s_rdata2", i), s_rdata2, tbl[i].e_s2);
      chk($sformatf("vec%0d_v_rdata1", i), v_rdata1, tbl[i].e_v1);
      chk($sformatf("vec%0d_v_rdata2", i), v_rdata2, tbl[i].e_v2);
      chk($sformatf("vec%0d_vlen", i), vlen, tbl[i].e_vlen);
    end
    s_we = 0; v_we = 0;

    // Load v2 = 0x20..0x27 for the streamer
    v_we = 1; v_waddr = 2; v_wdata = ln(32'h20, 8); v_mask_en = 0;
    tick;
    v_we = 0;

    // Stream 4 elements with st_ready held high
    st_ready = 1;
    stream_start(2, 4);
    chk("s1_valid0", st_valid, 1);
    chk("s1_busy0", st_busy, 1);
    chk("s1_data0", st_data, 32'h20);
    for (int k = 1; k < 4; k++) begin
      tick;
      chk($sformatf("s1_data%0d", k), st_data, 32'h20 + 32'(k));
      chk($sformatf("s1_valid%0d", k), st_valid, 1);
    end
    tick;
    chk("s1_done", st_done, 1);
    chk("s1_done_valid", st_valid, 0);
    chk("s1_done_busy", st_busy, 0);
    tick;
    chk("s1_done_pulse", st_done, 0);

    // Stall on the second element; a start while busy is ignored
    stream_start(2, 4);
    chk("s2_data0", st_data, 32'h20);
    tick;
    chk("s2_data1", st_data, 32'h21);
    st_ready = 0; st_start = 1; st_vreg = 1; st_cnt = 8;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("s2_hold%0d", k), st_data, 32'h21);
      chk($sformatf("s2_hold_valid%0d", k), st_valid, 1);
    end
    st_ready = 1; st_start = 0; st_vreg = 2;
    tick;
    chk("s2_data2", st_data, 32'h22);
    tick;
    chk("s2_data3", st_data, 32'h23);
    tick;
    chk("s2_done", st_done, 1);
    tick;
    chk("s2_idle_valid", st_valid, 0);
    chk("s2_idle_done", st_done, 0);

    // Zero-length stream
    stream_start(2, 0);
    chk("c0_done", st_done, 1);
    chk("c0_valid", st_valid, 0);
    tick;
    chk("c0_after_done", st_done, 0);
    chk("c0_after_valid", st_valid, 0);

    // Count above VLANES clamps to 8 elements
    stream_start(2, 15);
    n = 0; got_done = 0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      if (st_valid) begin
        chk($sformatf("c15_data%0d", n), st_data, 32'h20 + 32'(n));
        n++;
      end
      if (st_done) got_done = 1;
      else tick;
    end
    chk("c15_count", n, 8);
    chk("c15_done_seen", got_done, 1);
    tick;

    // Reset mid-stream aborts without st_done
    stream_start(2, 8);
    tick;
    chk("rs_data1", st_data, 32'h21);
    rst_n = 0;
    tick;
    chk("rs_valid", st_valid, 0);
    chk("rs_busy", st_busy, 0);
    chk("rs_done", st_done, 0);
    chk("rs_data", st_data, 0);
    chk("rs_vlen", vlen, 0);
    rst_n = 1;
    tick;
    chk("rs_after_done", st_done, 0);
    chk("rs_after_busy", st_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
